// File: rtl/speed_ctrl.sv
// speed_ctrl -- push-button speed selector.
//
// Two bouncy, active-low board buttons are synchronised, debounced and
// edge-detected. Each accepted press steps a saturating 4-bit speed code by
// one; that code drives the downstream counter's toggle rate.
//
// Ports (speed_ctrl):
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   btn_up_n       in   1  raw up button, active-low, asynchronous, bouncy
//   btn_dn_n       in   1  raw down button, active-low, asynchronous, bouncy
//   speed          out  4  current speed code (0..15, saturating)
//   speed_changed  out  1  one-cycle pulse on the cycle speed takes a new value
//   up_held        out  1  debounced up-button state, 1 = pressed
//   dn_held        out  1  debounced down-button state, 1 = pressed
//
// Ports (speed_ctrl_debounce, one per button):
//   clk, rst_n     in   1  as above
//   btn_n          in   1  raw active-low button
//   held           out  1  debounced state, 1 = pressed
//
// Timing, counting the first clk edge that samples a new stable raw level as
// edge 1: held changes at edge DEBOUNCE_CYCLES+2, speed/speed_changed at
// edge DEBOUNCE_CYCLES+3.

module speed_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic held
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0]    sync_ff;
    logic          sync;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Two-flop synchroniser; presetting to 1 makes the button look released
    // straight out of reset, so a held button needs a full interval again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], btn_n};
        end
    end

    assign sync = ~sync_ff[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter counts samples of the candidate level seen so far; entering
    // a WAIT state already accounts for the first one, so it never exceeds
    // DEBOUNCE_CYCLES-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RELEASED: begin
                if (sync) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Decoded from the state register so it is reset immediately with it.
    assign held = (state == PRESSED) || (state == RELEASE_WAIT);
endmodule

module speed_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RESET_SPEED     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_n,
    input  logic       btn_dn_n,
    output logic [3:0] speed,
    output logic       speed_changed,
    output logic       up_held,
    output logic       dn_held
);
    logic up_prev;
    logic dn_prev;
    logic up_press;
    logic dn_press;

    speed_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_up_n),
        .held  (up_held)
    );

    speed_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_dn_n),
        .held  (dn_held)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_prev <= 1'b0;
            dn_prev <= 1'b0;
        end else begin
            up_prev <= up_held;
            dn_prev <= dn_held;
        end
    end

    // Press = rising edge of held; releases are deliberately ignored.
    assign up_press = up_held & ~up_prev;
    assign dn_press = dn_held & ~dn_prev;

    // Simultaneous up and down presses cancel; saturated steps leave the
    // pulse low because the value does not actually change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed         <= 4'(RESET_SPEED);
            speed_changed <= 1'b0;
        end else begin
            speed_changed <= 1'b0;
            if (up_press && !dn_press && (speed != 4'd15)) begin
                speed         <= speed + 4'd1;
                speed_changed <= 1'b1;
            end else if (dn_press && !up_press && (speed != 4'd0)) begin
                speed         <= speed - 4'd1;
                speed_changed <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_speed_ctrl.sv
// Self-checking bench for speed_ctrl with DEBOUNCE_CYCLES=4, RESET_SPEED=0.
// A behavioural model predicts every output each cycle: a button's debounced
// state flips once the last DC raw levels seen through the two-cycle
// synchroniser all disagree with it, and the speed code moves one step on the
// cycle after a debounced press appears. Directed tasks add their own checks.
module tb_speed_ctrl;
    localparam int DC = 4;
    localparam int RS = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up_n = 1'b1;
    logic       btn_dn_n = 1'b1;
    logic [3:0] speed;
    logic       speed_changed;
    logic       up_held;
    logic       dn_held;

    int n_cmp = 0;
    int n_bad = 0;
    int obs_pulses = 0;

    speed_ctrl #(.DEBOUNCE_CYCLES(DC), .RESET_SPEED(RS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_up_n      (btn_up_n),
        .btn_dn_n      (btn_dn_n),
        .speed         (speed),
        .speed_changed (speed_changed),
        .up_held       (up_held),
        .dn_held       (dn_held)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    int m_speed = RS;
    bit m_changed = 1'b0;
    bit m_up = 1'b0;
    bit m_dn = 1'b0;
    bit m_up_prev = 1'b0;
    bit m_dn_prev = 1'b0;
    bit dly_up[$];
    bit dly_dn[$];
    bit hist_up[$];
    bit hist_dn[$];
    bit up_ev;
    bit dn_ev;

    function automatic bit run_differs(input bit q[$], input bit held);
        if (q.size() < DC) return 1'b0;
        foreach (q[i]) if (q[i] == held) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_speed   = RS;
                m_changed = 1'b0;
                m_up      = 1'b0;
                m_dn      = 1'b0;
                m_up_prev = 1'b0;
                m_dn_prev = 1'b0;
                dly_up    = '{1'b0, 1'b0};
                dly_dn    = '{1'b0, 1'b0};
                hist_up.delete();
                hist_dn.delete();
            end else begin
                up_ev     = m_up && !m_up_prev;
                dn_ev     = m_dn && !m_dn_prev;
                m_changed = 1'b0;
                if (up_ev && !dn_ev && m_speed < 15) begin
                    m_speed   = m_speed + 1;
                    m_changed = 1'b1;
                end else if (dn_ev && !up_ev && m_speed > 0) begin
                    m_speed   = m_speed - 1;
                    m_changed = 1'b1;
                end
                m_up_prev = m_up;
                m_dn_prev = m_dn;
                hist_up.push_back(dly_up.pop_front());
                hist_dn.push_back(dly_dn.pop_front());
                dly_up.push_back(!btn_up_n);
                dly_dn.push_back(!btn_dn_n);
                if (hist_up.size() > DC) void'(hist_up.pop_front());
                if (hist_dn.size() > DC) void'(hist_dn.pop_front());
                if (run_differs(hist_up, m_up)) m_up = !m_up;
                if (run_differs(hist_dn, m_dn)) m_dn = !m_dn;
            end
        end
    end

    // ---------------- scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if ({speed, speed_changed, up_held, dn_held} !==
                {4'(m_speed), m_changed, m_up, m_dn}) begin
                n_bad++;
                $display("FAIL sb t=%0t got speed=%0d chg=%0b up=%0b dn=%0b want speed=%0d chg=%0b up=%0b dn=%0b",
                         $time, speed, speed_changed, up_held, dn_held,
                         m_speed, m_changed, m_up, m_dn);
            end
            if (speed_changed === 1'b1) obs_pulses++;
        end
    end

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input bit up, input bit dn, input int hold, input int rel);
        btn_up_n = !up;
        btn_dn_n = !dn;
        repeat (hold) @(negedge clk);
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (rel) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        rst_n    = 1'b0;
        #25;
        n_cmp++;
        if (speed !== 4'(RS)) begin n_bad++; $display("FAIL reset_speed got %0d want %0d", speed, RS); end
        n_cmp++;
        if (speed_changed !== 1'b0) begin n_bad++; $display("FAIL reset_chg got %0b want 0", speed_changed); end
        n_cmp++;
        if ({up_held, dn_held} !== 2'b00) begin n_bad++; $display("FAIL reset_held got %b want 00", {up_held, dn_held}); end
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_presses();
        int lat;
        apply_reset();
        obs_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            btn_up_n = 1'b0;
            lat = 0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (speed_changed === 1'b1 && lat == 0) lat = k;
            end
            btn_up_n = 1'b1;
            repeat (10) @(negedge clk);
            n_cmp++;
            if (lat != DC + 3) begin n_bad++; $display("FAIL clean_latency press=%0d got edge %0d want %0d", i, lat, DC + 3); end
            n_cmp++;
            if (speed !== 4'(i + 1)) begin n_bad++; $display("FAIL clean_speed press=%0d got %0d want %0d", i, speed, i + 1); end
        end
        n_cmp++;
        if (obs_pulses != 3) begin n_bad++; $display("FAIL clean_pulses got %0d want 3", obs_pulses); end
    endtask

    task automatic test_bounce();
        bit seen;
        apply_reset();
        obs_pulses = 0;
        seen = 1'b0;
        btn_up_n = 1'b0;
        repeat (DC - 1) begin @(negedge clk); if (up_held === 1'b1) seen = 1'b1; end
        btn_up_n = 1'b1;
        repeat (10) begin @(negedge clk); if (up_held === 1'b1) seen = 1'b1; end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL bounce_held got 1 want 0"); end
        n_cmp++;
        if (speed !== 4'd0 || obs_pulses != 0) begin n_bad++; $display("FAIL bounce_speed got speed=%0d pulses=%0d want 0/0", speed, obs_pulses); end
    endtask

    task automatic test_saturation();
        apply_reset();
        repeat (15) press(1'b1, 1'b0, 8, 8);
        n_cmp++;
        if (speed !== 4'd15) begin n_bad++; $display("FAIL sat_top_reach got %0d want 15", speed); end
        obs_pulses = 0;
        press(1'b1, 1'b0, 8, 8);
        n_cmp++;
        if (speed !== 4'd15 || obs_pulses != 0) begin n_bad++; $display("FAIL sat_top got speed=%0d pulses=%0d want 15/0", speed, obs_pulses); end
        repeat (15) press(1'b0, 1'b1, 8, 8);
        n_cmp++;
        if (speed !== 4'd0) begin n_bad++; $display("FAIL sat_bot_reach got %0d want 0", speed); end
        obs_pulses = 0;
        press(1'b0, 1'b1, 8, 8);
        n_cmp++;
        if (speed !== 4'd0 || obs_pulses != 0) begin n_bad++; $display("FAIL sat_bot got speed=%0d pulses=%0d want 0/0", speed, obs_pulses); end
    endtask

    task automatic test_both();
        apply_reset();
        repeat (5) press(1'b1, 1'b0, 8, 8);
        obs_pulses = 0;
        btn_up_n = 1'b0;
        btn_dn_n = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({up_held, dn_held} !== 2'b11) begin n_bad++; $display("FAIL both_held got %b want 11", {up_held, dn_held}); end
        n_cmp++;
        if (speed !== 4'd5 || obs_pulses != 0) begin n_bad++; $display("FAIL both_speed got speed=%0d pulses=%0d want 5/0", speed, obs_pulses); end
        btn_dn_n = 1'b1;
        repeat (10) @(negedge clk);
        btn_dn_n = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (speed !== 4'd4) begin n_bad++; $display("FAIL both_redown got %0d want 4", speed); end
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_hold_and_chatter();
        bit dropped;
        bit chatter[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        obs_pulses = 0;
        btn_up_n = 1'b0;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (speed !== 4'd1 || obs_pulses != 1) begin n_bad++; $display("FAIL hold_once got speed=%0d pulses=%0d want 1/1", speed, obs_pulses); end
        dropped = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn_up_n = chatter[i];
            @(negedge clk);
            if (up_held !== 1'b1) dropped = 1'b1;
        end
        btn_up_n = 1'b1;
        for (int k = 1; k <= DC + 1; k++) begin
            @(negedge clk);
            if (up_held !== 1'b1) dropped = 1'b1;
        end
        n_cmp++;
        if (dropped) begin n_bad++; $display("FAIL chatter_held got 0 want 1 before stable release"); end
        @(negedge clk);
        n_cmp++;
        if (up_held !== 1'b0) begin n_bad++; $display("FAIL release_edge got %0b want 0 at edge %0d", up_held, DC + 2); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_press();
        int lat;
        apply_reset();
        repeat (7) press(1'b1, 1'b0, 8, 8);
        n_cmp++;
        if (speed !== 4'd7) begin n_bad++; $display("FAIL midrst_setup got %0d want 7", speed); end
        btn_up_n = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (speed !== 4'd0 || speed_changed !== 1'b0 || up_held !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_immediate got speed=%0d chg=%0b up=%0b want 0/0/0", speed, speed_changed, up_held);
        end
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (speed === 4'd1 && lat == 0) lat = k;
        end
        n_cmp++;
        if (lat != DC + 3) begin n_bad++; $display("FAIL midrst_latency got edge %0d want %0d", lat, DC + 3); end
        btn_up_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        int up_left = 0;
        int dn_left = 0;
        apply_reset();
        obs_pulses = 0;
        repeat (3000) begin
            if (up_left <= 0) begin btn_up_n = ~btn_up_n; up_left = $urandom_range(1, 10); end
            if (dn_left <= 0) begin btn_dn_n = ~btn_dn_n; dn_left = $urandom_range(1, 14); end
            @(negedge clk);
            up_left--;
            dn_left--;
        end
        n_cmp++;
        if (obs_pulses == 0) begin n_bad++; $display("FAIL random_activity got 0 pulses want >0"); end
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_clean_presses();
        test_bounce();
        test_saturation();
        test_both();
        test_hold_and_chatter();
        test_reset_mid_press();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t sequence did not complete", $time);
        $fatal(1, "watchdog");
    end
endmodule
